alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares the single 16-bit ALU between two requesters.
- Port 0 is the execute stage and has priority. Port 1 is a secondary requester (address/debug calc) and is protected against starvation by a wait counter.
- Drives the ALU operand, control and flag-enable inputs; registers the ALU result back to the granted requester one cycle later.
- Sits between the decode/execute logic and the ALU instance.

Parameters:
- WAIT_MAX, 4, number of consecutive cycles port 1 may be denied before it is forced a grant (legal range 1..15).
- CNT_W, 4, width of the starvation counter; must satisfy 2^CNT_W > WAIT_MAX.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset
- req0  input  1  port 0 request; held until gnt0
- ctrl0  input  3  port 0 ALU opcode (add, lhb, sub, and, nor, sll, srl, sra encoding)
- a0  input  16  port 0 src0
- b0  input  16  port 0 src1
- shamt0  input  4  port 0 shift amount
- setf0  input  1  port 0 flag-update request
- req1, ctrl1, a1, b1, shamt1, setf1: same as port 0, for port 1
- gnt0  output  1  port 0 granted this cycle (combinational)
- gnt1  output  1  port 1 granted this cycle (combinational)
- stall0  output  1  req0 & ~gnt0
- alu_src0  output  16  to ALU src0
- alu_src1  output  16  to ALU src1
- alu_ctrl  output  3  to ALU ctrl
- alu_shamt  output  4  to ALU shamt
- alu_op  output  1  to ALU aluOp (flag update enable)
- alu_dst  input  16  from ALU dst
- rsp_valid0  output  1  registered result valid for port 0
- rsp_valid1  output  1  registered result valid for port 1
- rsp_data  output  16  registered ALU result
- starve_cnt  output  CNT_W  current port 1 wait count (observability)

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - rsp_valid0 = rsp_valid1 = 0, rsp_data = 0, starve_cnt = 0.
  - gnt0 = gnt1 = 0 while rst_n is low.
  - Reset mid-operation drops any pending response; no response is issued after reset releases.
- Grant rules, evaluated each cycle from current req0/req1 and registered starve_cnt:
  - force1 = req1 & (starve_cnt == WAIT_MAX).
  - gnt1 = req1 & (~req0 | force1).
  - gnt0 = req0 & ~gnt1.
  - At most one grant per cycle.
- Operand mux (combinational):
  - When gnt0, alu_* come from port 0 fields; when gnt1, from port 1 fields.
  - alu_op = setf of the granted port.
  - With no grant: alu_src0 = alu_src1 = 0, alu_ctrl = 0, alu_shamt = 0, alu_op = 0. No flag change in idle cycles.
- Handshake:
  - Requester fields are sampled in the grant cycle only.
  - A requester holds req and fields stable until it sees gnt, then may deassert or present a new op the next cycle.
  - Back-to-back grants to the same port are legal.
- Response: at the clk edge ending a grant cycle:
  - rsp_data <= alu_dst.
  - rsp_validN <= gntN.
  - Latency is exactly 1 cycle. rsp_valid is a 1-cycle pulse per grant.
  - rsp_data holds its value when there is no grant.
- Starvation counter, updated at the clk edge:
  - if gnt1 or ~req1: starve_cnt <= 0
  - else if req1 & ~gnt1: starve_cnt <= starve_cnt + 1, saturating at WAIT_MAX.
- Boundary conditions:
  - Under continuous req0 and req1, port 1 is granted once every WAIT_MAX+1 cycles.
  - A forced gnt1 stalls port 0 for exactly that cycle; stall0 = 1.
  - If req1 drops while counting, the counter clears; no forced grant occurs with req1 = 0.
  - Simultaneous first requests: port 0 wins unless force1.
- Flags (V, Z, N) remain owned by the ALU. The arbiter guarantees aluOp is asserted only in a grant cycle whose requester set setf.

Test Plan:
- Reset: hold rst_n = 0 with req0 = req1 = 1 -> gnt0 = gnt1 = 0, rsp_valid0/1 = 0, rsp_data = 0000, starve_cnt = 0.
- Single port 0 op: req0 = 1, ctrl0 = add, a0 = 0003, b0 = 0004, setf0 = 1 -> gnt0 = 1 and alu_op = 1 that cycle; next cycle rsp_valid0 = 1, rsp_data = 0007, rsp_valid1 = 0.
- Port 1 alone: req1 = 1, ctrl1 = sll, b1 = 0001, shamt1 = 4, setf1 = 0 -> gnt1 = 1 immediately with alu_op = 0; next cycle rsp_valid1 = 1, rsp_data = 0010.
- Starvation, WAIT_MAX = 4: req0 and req1 held high continuously ->
  - cycles 0-3: gnt0, starve_cnt goes 1..4.
  - cycle 4: gnt1, stall0 = 1.
  - cycle 5: counter back to 0, pattern repeats every 5 cycles.
- req1 withdrawn at starve_cnt = 3 while req0 is high -> starve_cnt = 0 the next cycle; no gnt1 is ever issued.
- Reset asserted the cycle after a grant, before the response edge -> rsp_valid stays 0 after reset releases; starve_cnt = 0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// ----------------------------------------------------------------------------
// alu_share_arbiter
//
// Lets two requesters share one 16-bit ALU. Port 0 (the execute stage) wins
// every conflict. Port 1 (address/debug calculation) wins only when nothing
// else wants the ALU, or when it has been denied WAIT_MAX cycles in a row.
// The grant, the operand mux and the flag-enable are combinational. The ALU
// result is registered and returned to the winning port one cycle later.
//
// Parameters
//   WAIT_MAX   consecutive denials port 1 tolerates before a forced grant (1..15)
//   CNT_W      starvation counter width; 2**CNT_W must exceed WAIT_MAX
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req0/ctrl0/a0/b0/shamt0/setf0   port 0 request and ALU fields
//   req1/ctrl1/a1/b1/shamt1/setf1   port 1 request and ALU fields
//   gnt0, gnt1                 combinational grants (at most one is high)
//   stall0                     port 0 is requesting but was not granted
//   alu_src0/alu_src1/alu_ctrl/alu_shamt/alu_op   drive the ALU instance
//   alu_dst                    result returned by the ALU
//   rsp_valid0, rsp_valid1     one-cycle result pulse to the granted port
//   rsp_data                   registered ALU result (held when idle)
//   starve_cnt                 current port 1 wait count
// ----------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int unsigned WAIT_MAX = 4,
  parameter int unsigned CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0,
  input  logic [2:0]       ctrl0,
  input  logic [15:0]      a0,
  input  logic [15:0]      b0,
  input  logic [3:0]       shamt0,
  input  logic             setf0,

  input  logic             req1,
  input  logic [2:0]       ctrl1,
  input  logic [15:0]      a1,
  input  logic [15:0]      b1,
  input  logic [3:0]       shamt1,
  input  logic             setf1,

  output logic             gnt0,
  output logic             gnt1,
  output logic             stall0,

  output logic [15:0]      alu_src0,
  output logic [15:0]      alu_src1,
  output logic [2:0]       alu_ctrl,
  output logic [3:0]       alu_shamt,
  output logic             alu_op,
  input  logic [15:0]      alu_dst,

  output logic             rsp_valid0,
  output logic             rsp_valid1,
  output logic [15:0]      rsp_data,
  output logic [CNT_W-1:0] starve_cnt
);

  localparam logic [CNT_W-1:0] WAIT_MAX_C = CNT_W'(WAIT_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [CNT_W-1:0] starve_cnt_q;
  logic [CNT_W-1:0] starve_cnt_d;
  logic             rsp_valid0_q;
  logic             rsp_valid1_q;
  logic [15:0]      rsp_data_q;

  logic             force1;
  logic             gnt0_w;
  logic             gnt1_w;

  // --------------------------------------------------------------------------
  // Grant logic. Gating with rst_n keeps both grants low (and hence the ALU
  // idle) for the whole time reset is held, even though requests may be high.
  // --------------------------------------------------------------------------
  assign force1 = req1 & (starve_cnt_q == WAIT_MAX_C);
  assign gnt1_w = rst_n & req1 & (~req0 | force1);
  assign gnt0_w = rst_n & req0 & ~gnt1_w;

  assign gnt0   = gnt0_w;
  assign gnt1   = gnt1_w;
  assign stall0 = req0 & ~gnt0_w;

  // --------------------------------------------------------------------------
  // Operand mux. Idle cycles drive zeros and, importantly, alu_op = 0 so the
  // ALU never updates its flags without a granted requester asking for it.
  // --------------------------------------------------------------------------
  always_comb begin
    alu_src0  = '0;
    alu_src1  = '0;
    alu_ctrl  = '0;
    alu_shamt = '0;
    alu_op    = 1'b0;
    if (gnt0_w) begin
      alu_src0  = a0;
      alu_src1  = b0;
      alu_ctrl  = ctrl0;
      alu_shamt = shamt0;
      alu_op    = setf0;
    end else if (gnt1_w) begin
      alu_src0  = a1;
      alu_src1  = b1;
      alu_ctrl  = ctrl1;
      alu_shamt = shamt1;
      alu_op    = setf1;
    end
  end

  // --------------------------------------------------------------------------
  // Starvation counter: counts consecutive cycles port 1 is requesting but
  // denied. Any grant to port 1, or port 1 going quiet, restarts the count.
  // Saturation is defensive; at WAIT_MAX force1 grants port 1 anyway.
  // --------------------------------------------------------------------------
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (gnt1_w || !req1) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != WAIT_MAX_C) begin
      starve_cnt_d = starve_cnt_q + CNT_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // State and response registers. The result is captured only in grant
  // cycles so rsp_data holds the last result across idle cycles. Reset
  // clears the valid pulses, so a grant cut short by reset never responds.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      rsp_valid0_q <= 1'b0;
      rsp_valid1_q <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rsp_valid0_q <= gnt0_w;
      rsp_valid1_q <= gnt1_w;
      if (gnt0_w || gnt1_w) begin
        rsp_data_q <= alu_dst;
      end
    end
  end

  assign rsp_valid0 = rsp_valid0_q;
  assign rsp_valid1 = rsp_valid1_q;
  assign rsp_data   = rsp_data_q;
  assign starve_cnt = starve_cnt_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ----------------------------------------------------------------------------
// Bench for alu_share_arbiter. A behavioural ALU is attached to the arbiter's
// ALU-side ports. Expected values come from the request fields and the
// arbitration rules (priority, denial count, one-cycle response), never from
// the DUT's own outputs. Inputs change 1 ns after a rising edge, combinational
// outputs are checked at the falling edge, registered outputs 1 ns after the
// next rising edge.
// ----------------------------------------------------------------------------
module tb_alu_share_arbiter;

  localparam int WAIT_MAX = 4;
  localparam int CNT_W    = 4;

  logic             clk;
  logic             rst_n;
  logic             req0, req1;
  logic [2:0]       ctrl0, ctrl1;
  logic [15:0]      a0, b0, a1, b1;
  logic [3:0]       shamt0, shamt1;
  logic             setf0, setf1;
  logic             gnt0, gnt1, stall0;
  logic [15:0]      alu_src0, alu_src1;
  logic [2:0]       alu_ctrl;
  logic [3:0]       alu_shamt;
  logic             alu_op;
  logic [15:0]      alu_dst;
  logic             rsp_valid0, rsp_valid1;
  logic [15:0]      rsp_data;
  logic [CNT_W-1:0] starve_cnt;

  int total = 0;
  int bad   = 0;

  alu_share_arbiter #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .ctrl0(ctrl0), .a0(a0), .b0(b0), .shamt0(shamt0), .setf0(setf0),
    .req1(req1), .ctrl1(ctrl1), .a1(a1), .b1(b1), .shamt1(shamt1), .setf1(setf1),
    .gnt0(gnt0), .gnt1(gnt1), .stall0(stall0),
    .alu_src0(alu_src0), .alu_src1(alu_src1), .alu_ctrl(alu_ctrl),
    .alu_shamt(alu_shamt), .alu_op(alu_op), .alu_dst(alu_dst),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1), .rsp_data(rsp_data),
    .starve_cnt(starve_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural ALU: add, lhb, sub, and, nor, sll, srl, sra (shifts act on src1).
  function automatic logic [15:0] alu_fn(input logic [2:0] c, input logic [15:0] a,
                                         input logic [15:0] b, input logic [3:0] s);
    case (c)
      3'd0:    return a + b;
      3'd1:    return {b[7:0], a[7:0]};
      3'd2:    return a - b;
      3'd3:    return a & b;
      3'd4:    return ~(a | b);
      3'd5:    return b << s;
      3'd6:    return b >> s;
      default: return 16'($signed(b) >>> s);
    endcase
  endfunction

  assign alu_dst = alu_fn(alu_ctrl, alu_src0, alu_src1, alu_shamt);

  task automatic clear_inputs();
    req0 = 0; ctrl0 = 0; a0 = 0; b0 = 0; shamt0 = 0; setf0 = 0;
    req1 = 0; ctrl1 = 0; a1 = 0; b1 = 0; shamt1 = 0; setf1 = 0;
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    req0 = 1; req1 = 1; a0 = 16'h1234; a1 = 16'h5678; setf0 = 1; setf1 = 1;
    next_cycle();
    next_cycle();
    total++; if ({gnt0, gnt1} !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b want=00", {gnt0, gnt1}); end
    total++; if ({rsp_valid0, rsp_valid1} !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid got=%b want=00", {rsp_valid0, rsp_valid1}); end
    total++; if (rsp_data !== 16'h0000) begin bad++; $display("FAIL reset_rsp_data got=%h want=0000", rsp_data); end
    total++; if (starve_cnt !== 0) begin bad++; $display("FAIL reset_starve_cnt got=%0d want=0", starve_cnt); end
    total++; if (alu_op !== 1'b0) begin bad++; $display("FAIL reset_alu_op got=%b want=0", alu_op); end
    $display("reset: gnt=%b%b rsp_valid=%b%b rsp_data=%h starve_cnt=%0d", gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_data, starve_cnt);
    clear_inputs();
    rst_n = 1;
    next_cycle();
  endtask

  task automatic test_single_port0();
    clear_inputs();
    req0 = 1; ctrl0 = 3'd0; a0 = 16'h0003; b0 = 16'h0004; setf0 = 1;
    #4;
    total++; if ({gnt0, gnt1, alu_op} !== 3'b101) begin bad++; $display("FAIL p0_grant gnt0/gnt1/alu_op got=%b want=101", {gnt0, gnt1, alu_op}); end
    total++; if ({alu_src0, alu_src1} !== {16'h0003, 16'h0004}) begin bad++; $display("FAIL p0_operands got=%h/%h want=0003/0004", alu_src0, alu_src1); end
    next_cycle();
    clear_inputs();
    total++; if ({rsp_valid0, rsp_valid1} !== 2'b10) begin bad++; $display("FAIL p0_rsp_valid got=%b want=10", {rsp_valid0, rsp_valid1}); end
    total++; if (rsp_data !== 16'h0007) begin bad++; $display("FAIL p0_rsp_data got=%h want=0007", rsp_data); end
    $display("port0 add: rsp_valid=%b%b rsp_data=%h", rsp_valid0, rsp_valid1, rsp_data);
    next_cycle();
    total++; if ({rsp_valid0, rsp_data} !== {1'b0, 16'h0007}) begin bad++; $display("FAIL p0_pulse_hold got=%b/%h want=0/0007", rsp_valid0, rsp_data); end
  endtask

  task automatic test_port1_alone();
    clear_inputs();
    req1 = 1; ctrl1 = 3'd5; a1 = 16'hFFFF; b1 = 16'h0001; shamt1 = 4'd4; setf1 = 0;
    #4;
    total++; if ({gnt0, gnt1, alu_op, stall0} !== 4'b0100) begin bad++; $display("FAIL p1_grant gnt0/gnt1/alu_op/stall0 got=%b want=0100", {gnt0, gnt1, alu_op, stall0}); end
    total++; if ({alu_ctrl, alu_shamt} !== {3'd5, 4'd4}) begin bad++; $display("FAIL p1_ctrl got=%0d/%0d want=5/4", alu_ctrl, alu_shamt); end
    next_cycle();
    clear_inputs();
    total++; if ({rsp_valid0, rsp_valid1} !== 2'b01) begin bad++; $display("FAIL p1_rsp_valid got=%b want=01", {rsp_valid0, rsp_valid1}); end
    total++; if (rsp_data !== 16'h0010) begin bad++; $display("FAIL p1_rsp_data got=%h want=0010", rsp_data); end
    $display("port1 sll: rsp_valid=%b%b rsp_data=%h", rsp_valid0, rsp_valid1, rsp_data);
    next_cycle();
  endtask

  // Continuous contention: in cycle k the wait count is k mod (WAIT_MAX+1) and
  // port 1 wins exactly when that count has reached WAIT_MAX.
  task automatic test_starvation();
    logic exp_g1;
    clear_inputs();
    req0 = 1; req1 = 1; ctrl0 = 3'd3; a0 = 16'h0F0F; b0 = 16'h00FF;
    ctrl1 = 3'd2; a1 = 16'h0100; b1 = 16'h0001;
    for (int k = 0; k < 3 * (WAIT_MAX + 1); k++) begin
      #4;
      exp_g1 = ((k % (WAIT_MAX + 1)) == WAIT_MAX);
      total++; if (starve_cnt !== CNT_W'(k % (WAIT_MAX + 1))) begin bad++; $display("FAIL starve_cnt cycle=%0d got=%0d want=%0d", k, starve_cnt, k % (WAIT_MAX + 1)); end
      total++; if ({gnt0, gnt1, stall0} !== {~exp_g1, exp_g1, exp_g1}) begin bad++; $display("FAIL starve_grant cycle=%0d gnt0/gnt1/stall0 got=%b want=%b", k, {gnt0, gnt1, stall0}, {~exp_g1, exp_g1, exp_g1}); end
      next_cycle();
      total++; if ({rsp_valid0, rsp_valid1, rsp_data} !== {~exp_g1, exp_g1, exp_g1 ? 16'h00FF : 16'h000F}) begin
        bad++; $display("FAIL starve_rsp cycle=%0d got=%b%b/%h", k, rsp_valid0, rsp_valid1, rsp_data);
      end
      $display("starve cycle %0d: gnt1=%b rsp_valid=%b%b rsp_data=%h", k, exp_g1, rsp_valid0, rsp_valid1, rsp_data);
    end
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_withdraw();
    clear_inputs();
    req0 = 1; req1 = 1;
    for (int k = 0; k < 3; k++) next_cycle();
    total++; if (starve_cnt !== CNT_W'(3)) begin bad++; $display("FAIL withdraw_count got=%0d want=3", starve_cnt); end
    req1 = 0;
    for (int k = 0; k < 2 * WAIT_MAX; k++) begin
      #4;
      total++; if ({gnt0, gnt1} !== 2'b10) begin bad++; $display("FAIL withdraw_grant cycle=%0d got=%b want=10", k, {gnt0, gnt1}); end
      next_cycle();
      total++; if (starve_cnt !== 0) begin bad++; $display("FAIL withdraw_clear cycle=%0d got=%0d want=0", k, starve_cnt); end
    end
    $display("withdraw: starve_cnt=%0d after req1 dropped", starve_cnt);
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    req0 = 1; req1 = 1; ctrl0 = 3'd0; a0 = 16'h1111; b0 = 16'h2222;
    next_cycle();
    next_cycle();
    #4;
    total++; if ({gnt0, starve_cnt} !== {1'b1, CNT_W'(2)}) begin bad++; $display("FAIL midrst_pre got gnt0=%b cnt=%0d want 1/2", gnt0, starve_cnt); end
    rst_n = 0;
    #1;
    total++; if ({gnt0, gnt1} !== 2'b00) begin bad++; $display("FAIL midrst_gnt_in_reset got=%b want=00", {gnt0, gnt1}); end
    next_cycle();
    clear_inputs();
    #1;
    rst_n = 1;
    total++; if ({rsp_valid0, rsp_valid1, starve_cnt} !== {2'b00, CNT_W'(0)}) begin bad++; $display("FAIL midrst_after got=%b%b cnt=%0d", rsp_valid0, rsp_valid1, starve_cnt); end
    total++; if (rsp_data !== 16'h0000) begin bad++; $display("FAIL midrst_rsp_data got=%h want=0000", rsp_data); end
    next_cycle();
    total++; if ({rsp_valid0, rsp_valid1} !== 2'b00) begin bad++; $display("FAIL midrst_late_rsp got=%b want=00", {rsp_valid0, rsp_valid1}); end
    $display("reset mid-op: rsp_valid=%b%b starve_cnt=%0d", rsp_valid0, rsp_valid1, starve_cnt);
  endtask

  // Random requests obeying the hold-until-granted handshake, compared with a
  // model that tracks how long port 1 has been waiting.
  task automatic test_random();
    int          denied;
    logic        pend0, pend1, e0, e1, exp_v0, exp_v1;
    logic [15:0] exp_data, exp_res;
    logic [39:0] exp_alu;
    denied = 0; pend0 = 0; pend1 = 0; exp_data = rsp_data;
    for (int n = 0; n < 300; n++) begin
      if (!pend0) begin
        req0 = ($urandom_range(0, 9) < 7); ctrl0 = 3'($urandom); a0 = 16'($urandom);
        b0 = 16'($urandom); shamt0 = 4'($urandom); setf0 = 1'($urandom);
      end
      if (!pend1) begin
        req1 = ($urandom_range(0, 9) < 6); ctrl1 = 3'($urandom); a1 = 16'($urandom);
        b1 = 16'($urandom); shamt1 = 4'($urandom); setf1 = 1'($urandom);
      end
      e1 = req1 && (!req0 || denied >= WAIT_MAX);
      e0 = req0 && !e1;
      if (e0) exp_alu = {a0, b0, ctrl0, shamt0, setf0};
      else if (e1) exp_alu = {a1, b1, ctrl1, shamt1, setf1};
      else exp_alu = '0;
      exp_res = e0 ? alu_fn(ctrl0, a0, b0, shamt0) : alu_fn(ctrl1, a1, b1, shamt1);
      #4;
      total++; if ({gnt0, gnt1, stall0} !== {e0, e1, req0 && !e0}) begin bad++; $display("FAIL rnd_grant n=%0d got=%b want=%b", n, {gnt0, gnt1, stall0}, {e0, e1, req0 && !e0}); end
      total++; if ({alu_src0, alu_src1, alu_ctrl, alu_shamt, alu_op} !== exp_alu) begin bad++; $display("FAIL rnd_alu n=%0d got=%h want=%h", n, {alu_src0, alu_src1, alu_ctrl, alu_shamt, alu_op}, exp_alu); end
      total++; if (starve_cnt !== CNT_W'(denied)) begin bad++; $display("FAIL rnd_cnt n=%0d got=%0d want=%0d", n, starve_cnt, denied); end
      next_cycle();
      exp_v0 = e0; exp_v1 = e1;
      if (e0 || e1) exp_data = exp_res;
      denied = (e1 || !req1) ? 0 : ((denied < WAIT_MAX) ? denied + 1 : WAIT_MAX);
      pend0 = req0 && !e0;
      pend1 = req1 && !e1;
      total++; if ({rsp_valid0, rsp_valid1, rsp_data} !== {exp_v0, exp_v1, exp_data}) begin
        bad++; $display("FAIL rnd_rsp n=%0d got=%b%b/%h want=%b%b/%h", n, rsp_valid0, rsp_valid1, rsp_data, exp_v0, exp_v1, exp_data);
      end
      $display("rnd %0d: req=%b%b gnt=%b%b rsp=%b%b/%h", n, req0, req1, e0, e1, rsp_valid0, rsp_valid1, rsp_data);
    end
    clear_inputs();
    next_cycle();
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    test_reset();
    test_single_port0();
    test_port1_alone();
    test_starvation();
    test_withdraw();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
